hdmi_in_timing_meas: RTL and testbench



---
 rtl/hdmi_in_timing_meas.sv | 177 +++++++++++++++++
 tb/tb_hdmi_in_timing_meas.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_in_timing_meas.sv
// hdmi_in_timing_meas
// Measures the timing of an incoming HDMI video stream and reports, once per
// frame, the horizontal total, horizontal active width, vertical total and
// vertical active height. Flags a stable format (locked) and a lost input
// (no_signal).
//
// Ports:
//   pixclk_in   pixel clock, the only clock
//   rst         synchronous active-high reset
//   vs_in       vertical sync (active level set by VS_POL)
//   hs_in       horizontal sync (active level set by HS_POL)
//   de_in       data enable
//   h_total     pixclk_in cycles per line
//   h_active    largest DE-high count seen in any line of the frame
//   v_total     lines per frame
//   v_active    lines of the frame with at least one DE-high cycle
//   meas_valid  one-cycle pulse when the four results update
//   locked      format unchanged for STABLE_FRAMES+1 captures
//   no_signal   no VS edge within TIMEOUT_CYC cycles, or in reset
module hdmi_in_timing_meas #(
   parameter int CNT_W         = 12,
   parameter int STABLE_FRAMES = 3,
   parameter int TIMEOUT_CYC   = 8388608,
   parameter int VS_POL        = 1,
   parameter int HS_POL        = 1
) (
   input  logic             pixclk_in,
   input  logic             rst,
   input  logic             vs_in,
   input  logic             hs_in,
   input  logic             de_in,
   output logic [CNT_W-1:0] h_total,
   output logic [CNT_W-1:0] h_active,
   output logic [CNT_W-1:0] v_total,
   output logic [CNT_W-1:0] v_active,
   output logic             meas_valid,
   output logic             locked,
   output logic             no_signal
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam int TW = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam int MW = $clog2(STABLE_FRAMES + 1);
   localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_FRAMES);

   typedef enum logic [1:0] {NO_SIG, ACQUIRE, TRACK} state_t;

   state_t state, state_nx;

   logic vs_n, hs_n;
   logic vs_s1, vs_s2, hs_s1, hs_s2, de_s1;
   logic vs_edge, hs_edge, timeout, capture, same_fmt;

   logic [CNT_W-1:0] pix_cnt, de_cnt, line_len, max_de, line_cnt, act_cnt;
   logic [CNT_W-1:0] line_len_nx, max_de_nx, line_cnt_nx, act_cnt_nx;
   logic [TW-1:0]    vs_timer;
   logic [MW-1:0]    match_cnt, match_nx;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // Syncs are normalised to active-high before the synchroniser.
   assign vs_n    = (VS_POL != 0) ? vs_in : ~vs_in;
   assign hs_n    = (HS_POL != 0) ? hs_in : ~hs_in;
   assign vs_edge = vs_s1 & ~vs_s2;
   assign hs_edge = hs_s1 & ~hs_s2;

   // A VS edge arriving in the very cycle the timer expires counts as in time.
   assign timeout = (vs_timer == TO_LAST) && !vs_edge;
   assign capture = vs_edge && (state != NO_SIG);

   // Line-end bookkeeping is folded in first, so a line that ends together
   // with the frame is counted into the ending frame.
   always_comb begin
      line_len_nx = line_len;
      max_de_nx   = max_de;
      line_cnt_nx = line_cnt;
      act_cnt_nx  = act_cnt;
      if (hs_edge) begin
         line_len_nx = pix_cnt;
         if (de_cnt > max_de) max_de_nx = de_cnt;
         line_cnt_nx = sat_inc(line_cnt);
         if (de_cnt != '0) act_cnt_nx = sat_inc(act_cnt);
      end
      same_fmt = (line_len_nx == h_total) && (max_de_nx == h_active) &&
                 (line_cnt_nx == v_total) && (act_cnt_nx == v_active);
      match_nx = '0;
      if (same_fmt && (line_cnt_nx != '0))
         match_nx = (match_cnt == MATCH_MAX) ? match_cnt : match_cnt + 1'b1;
   end

   always_comb begin
      state_nx = state;
      case (state)
         NO_SIG:  if (vs_edge) state_nx = ACQUIRE;
         ACQUIRE: if (vs_edge) state_nx = TRACK;
         TRACK:   state_nx = TRACK;
         default: state_nx = NO_SIG;
      endcase
      if (timeout) state_nx = NO_SIG;
   end

   always_ff @(posedge pixclk_in) begin
      if (rst) state <= NO_SIG;
      else     state <= state_nx;
   end

   always_ff @(posedge pixclk_in) begin
      if (rst) begin
         vs_s1      <= 1'b0;
         vs_s2      <= 1'b0;
         hs_s1      <= 1'b0;
         hs_s2      <= 1'b0;
         de_s1      <= 1'b0;
         pix_cnt    <= '0;
         de_cnt     <= '0;
         line_len   <= '0;
         max_de     <= '0;
         line_cnt   <= '0;
         act_cnt    <= '0;
         vs_timer   <= '0;
         match_cnt  <= '0;
         h_total    <= '0;
         h_active   <= '0;
         v_total    <= '0;
         v_active   <= '0;
         meas_valid <= 1'b0;
         locked     <= 1'b0;
         no_signal  <= 1'b1;
      end else begin
         vs_s1      <= vs_n;
         vs_s2      <= vs_s1;
         hs_s1      <= hs_n;
         hs_s2      <= hs_s1;
         de_s1      <= de_in;
         pix_cnt    <= hs_edge ? CNT_W'(1) : sat_inc(pix_cnt);
         de_cnt     <= hs_edge ? CNT_W'(de_s1) : (de_s1 ? sat_inc(de_cnt) : de_cnt);
         line_len   <= line_len_nx;
         meas_valid <= capture;

         if (vs_edge)                vs_timer <= '0;
         else if (vs_timer != TO_LAST) vs_timer <= vs_timer + 1'b1;

         // Every VS edge starts a fresh frame, including the first one out of NO_SIG.
         if (vs_edge) begin
            max_de   <= '0;
            line_cnt <= '0;
            act_cnt  <= '0;
         end else begin
            max_de   <= max_de_nx;
            line_cnt <= line_cnt_nx;
            act_cnt  <= act_cnt_nx;
         end

         if (timeout) begin
            h_total   <= '0;
            h_active  <= '0;
            v_total   <= '0;
            v_active  <= '0;
            match_cnt <= '0;
            locked    <= 1'b0;
            no_signal <= 1'b1;
         end else if (capture) begin
            h_total   <= line_len_nx;
            h_active  <= max_de_nx;
            v_total   <= line_cnt_nx;
            v_active  <= act_cnt_nx;
            match_cnt <= match_nx;
            locked    <= (match_nx == MATCH_MAX);
            no_signal <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hdmi_in_timing_meas.sv
// tb_hdmi_in_timing_meas
// Drives synthetic video frames into two instances of hdmi_in_timing_meas:
// a 12-bit active-high instance and a 5-bit inverted-polarity instance fed
// with inverted syncs. Expected per-frame results come from the frame
// parameters themselves (line length, line count, per-line DE length).
module tb_hdmi_in_timing_meas;

   localparam int S = 3;
   localparam int T = 1000;

   typedef struct {
      int ht;
      int ha;
      int vt;
      int va;
      bit lk;
   } exp_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic rst, vs, hs, de, vsInv, hsInv;
   assign vsInv = ~vs;
   assign hsInv = ~hs;

   logic [11:0] htA, haA, vtA, vaA;
   logic        mvA, lkA, nsA;
   logic [4:0]  htB, haB, vtB, vaB;
   logic        mvB, lkB, nsB;

   hdmi_in_timing_meas #(.CNT_W(12), .STABLE_FRAMES(S), .TIMEOUT_CYC(T),
                         .VS_POL(1), .HS_POL(1)) dut (
      .pixclk_in(clock), .rst(rst), .vs_in(vs), .hs_in(hs), .de_in(de),
      .h_total(htA), .h_active(haA), .v_total(vtA), .v_active(vaA),
      .meas_valid(mvA), .locked(lkA), .no_signal(nsA));

   hdmi_in_timing_meas #(.CNT_W(5), .STABLE_FRAMES(S), .TIMEOUT_CYC(T),
                         .VS_POL(0), .HS_POL(0)) dut_p (
      .pixclk_in(clock), .rst(rst), .vs_in(vsInv), .hs_in(hsInv), .de_in(de),
      .h_total(htB), .h_active(haB), .v_total(vtB), .v_active(vaB),
      .meas_valid(mvB), .locked(lkB), .no_signal(nsB));

   int checks = 0;
   int errors = 0;

   exp_t expA[$];
   exp_t expB[$];
   exp_t lastA, lastB;
   int   runA = 0, runB = 0;
   int   edges = 0;
   int   prevL = 0, prevN = 0, prevMax = 0, prevAct = 0;
   int   deLen[16];

   function automatic int sat(input int v, input int w);
      int lim;
      lim = (1 << w) - 1;
      return (v > lim) ? lim : v;
   endfunction

   function automatic bit sameTuple(input exp_t x, input exp_t y);
      return (x.ht == y.ht) && (x.ha == y.ha) && (x.vt == y.vt) && (x.va == y.va);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Locked means the last S+1 captures since reset/timeout were identical.
   task automatic recordCapture(input int l, input int n, input int mx, input int act);
      exp_t a, b;
      a.ht = sat(l, 12); a.ha = sat(mx, 12); a.vt = sat(n, 12); a.va = sat(act, 12);
      b.ht = sat(l, 5);  b.ha = sat(mx, 5);  b.vt = sat(n, 5);  b.va = sat(act, 5);
      if (runA > 0 && sameTuple(a, lastA)) runA++; else runA = 1;
      if (runB > 0 && sameTuple(b, lastB)) runB++; else runB = 1;
      a.lk = (runA >= S + 1);
      b.lk = (runB >= S + 1);
      lastA = a;
      lastB = b;
      expA.push_back(a);
      expB.push_back(b);
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_ht"}, htA, 0);
      checkOutput({tag, "_ha"}, haA, 0);
      checkOutput({tag, "_vt"}, vtA, 0);
      checkOutput({tag, "_va"}, vaA, 0);
      checkOutput({tag, "_locked"}, lkA, 0);
      checkOutput({tag, "_no_signal"}, nsA, 1);
      checkOutput({tag, "_ht_p"}, htB, 0);
      checkOutput({tag, "_locked_p"}, lkB, 0);
      checkOutput({tag, "_no_signal_p"}, nsB, 1);
   endtask

   // One frame: VS in line 0 starting at vsOff, 2-cycle HS at each line start,
   // DE from cycle 3 for deLen[j] cycles. rstLine >= 0 pulses rst mid-frame.
   task automatic applyStimulus(input int lineLen, input int lines, input int vsOff, input int rstLine);
      int mx, act;
      mx = 0;
      act = 0;
      for (int j = 0; j < lines; j++) begin
         if (deLen[j] > mx) mx = deLen[j];
         if (deLen[j] != 0) act++;
      end
      if (edges >= 1) recordCapture(prevL, prevN, prevMax, prevAct);
      edges++;
      for (int j = 0; j < lines; j++) begin
         for (int c = 0; c < lineLen; c++) begin
            @(negedge clock);
            rst = (j == rstLine) && (c == 5);
            hs  = (c < 2);
            de  = (c >= 3) && (c < 3 + deLen[j]);
            vs  = (j == 0) && (c >= vsOff) && (c < vsOff + 3);
            if (j == rstLine && c == 5) begin
               edges = 0;
               runA = 0;
               runB = 0;
            end
            if (j == rstLine && c == 6) checkIdle("mid_reset");
         end
      end
      prevL = lineLen;
      prevN = lines;
      prevMax = mx;
      prevAct = act;
   endtask

   task automatic applyIdle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clock);
         rst = 1'b0;
         vs  = 1'b0;
         de  = 1'b0;
         hs  = ((i % 20) < 2);
      end
      edges = 0;
      runA = 0;
      runB = 0;
   endtask

   task automatic setDe(input int lines, input int active, input int len);
      for (int j = 0; j < 16; j++) deLen[j] = (j < lines && j < active) ? len : 0;
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (mvA || mvB) begin
         checkOutput("pulse_align", mvB, mvA);
         if (mvA) begin
            if (expA.size() == 0) checkOutput("unexpected_meas_valid", expA.size(), 1);
            else begin
               e = expA.pop_front();
               checkOutput("h_total", htA, e.ht);
               checkOutput("h_active", haA, e.ha);
               checkOutput("v_total", vtA, e.vt);
               checkOutput("v_active", vaA, e.va);
               checkOutput("locked", lkA, e.lk);
               checkOutput("no_signal", nsA, 0);
            end
         end
         if (mvB) begin
            if (expB.size() == 0) checkOutput("unexpected_meas_valid_p", expB.size(), 1);
            else begin
               e = expB.pop_front();
               checkOutput("h_total_p", htB, e.ht);
               checkOutput("h_active_p", haB, e.ha);
               checkOutput("v_total_p", vtB, e.vt);
               checkOutput("v_active_p", vaB, e.va);
               checkOutput("locked_p", lkB, e.lk);
               checkOutput("no_signal_p", nsB, 0);
            end
         end
      end
   end

   initial begin
      int l, n;
      rst = 1'b1;
      vs = 1'b0;
      hs = 1'b0;
      de = 1'b0;
      repeat (3) @(negedge clock);
      rst = 1'b0;
      repeat (2) @(negedge clock);
      checkIdle("reset");
      checkOutput("reset_meas_valid", mvA, 0);

      $display("[TB] basic lock, coincident HS/VS edges");
      setDe(10, 6, 12);
      repeat (6) applyStimulus(20, 10, 0, -1);

      $display("[TB] format change to 11-cycle DE");
      setDe(10, 6, 11);
      repeat (5) applyStimulus(20, 10, 2, -1);

      $display("[TB] random formats");
      for (int k = 0; k < 3; k++) begin
         l = $urandom_range(30, 16);
         n = $urandom_range(12, 6);
         for (int j = 0; j < 16; j++)
            deLen[j] = (j < n && $urandom_range(3, 0) != 0) ? $urandom_range(l - 4, 1) : 0;
         repeat (5) applyStimulus(l, n, $urandom_range(5, 0), -1);
      end

      $display("[TB] saturation with 40-cycle lines");
      setDe(10, 6, 12);
      repeat (5) applyStimulus(40, 10, 1, -1);

      $display("[TB] reset mid-frame while locked");
      checkOutput("locked_before_reset", lkA, 1);
      applyStimulus(40, 10, 1, 3);
      repeat (3) applyStimulus(40, 10, 1, -1);
      checkOutput("pending_before_timeout", expA.size(), 0);

      $display("[TB] timeout");
      applyIdle(1200);
      checkIdle("timeout");

      $display("[TB] recovery after timeout");
      setDe(10, 6, 12);
      repeat (6) applyStimulus(20, 10, 0, -1);
      repeat (4) @(negedge clock);
      checkOutput("locked_after_recovery", lkA, 1);

      checkOutput("pending_captures", expA.size(), 0);
      checkOutput("pending_captures_p", expB.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
